// File: rtl/d_ext_pipe.sv
// Registered operand extender: immediate and load-data sign/zero extension
// feeding a 2-entry valid/ready skid buffer with flush.
module d_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ext_op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_SIGN = 3'd1;
  localparam logic [2:0] OP_LUI  = 3'd2;
  localparam logic [2:0] OP_LB   = 3'd3;
  localparam logic [2:0] OP_LBU  = 3'd4;
  localparam logic [2:0] OP_LH   = 3'd5;
  localparam logic [2:0] OP_LHU  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;

  assign byte_lane = data[{offset, 3'b000} +: 8];
  assign half_lane = data[{offset[OFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (ext_op)
      OP_ZERO: ext_data = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_SIGN: ext_data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      OP_LUI:  ext_data = {imm, {(DATA_W-IMM_W){1'b0}}};
      OP_LB:   ext_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      OP_LBU:  ext_data = {{(DATA_W-8){1'b0}}, byte_lane};
      OP_LH, OP_LHU: begin
        // A misaligned half returns zero data and raises the error flag.
        if (offset[0]) begin
          ext_err = 1'b1;
        end else begin
          ext_data = {{(DATA_W-16){(ext_op == OP_LH) & half_lane[15]}}, half_lane};
        end
      end
      OP_PASS: ext_data = data;
      default: ext_data = '0;
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the opposite side's valid/ready, and a
  // producer holds its payload stable while valid is high and ready is low.
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [DATA_W-1:0] ent_data [2];
  logic              ent_err  [2];
  logic              push;
  logic              pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = ent_data[rd_ptr];
  assign out_err   = ent_err[rd_ptr];
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      ent_data[0] <= '0;
      ent_data[1] <= '0;
      ent_err[0]  <= 1'b0;
      ent_err[1]  <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        ent_data[wr_ptr] <= ext_data;
        ent_err[wr_ptr]  <= ext_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_d_ext_pipe.sv
// Directed bench for d_ext_pipe: 32-bit and 64-bit instances, extension
// modes, misalignment, backpressure, flush, mid-stream reset and streaming.
module tb_d_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [2:0]  a_op;
  logic [15:0] a_imm;
  logic [31:0] a_data, a_out_data;
  logic [1:0]  a_off;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [2:0]  b_op;
  logic [15:0] b_imm;
  logic [63:0] b_data, b_out_data;
  logic [2:0]  b_off;

  d_ext_pipe dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ext_op(a_op), .imm(a_imm), .data(a_data), .offset(a_off),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_err(a_out_err)
  );

  d_ext_pipe #(.DATA_W(64), .IMM_W(16)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ext_op(b_op), .imm(b_imm), .data(b_data), .offset(b_off),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_err(b_out_err)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [15:0] imm,
                       input logic [31:0] data, input logic [1:0] off);
    a_in_valid = 1'b1;
    a_op = op; a_imm = imm; a_data = data; a_off = off;
  endtask

  task automatic set_b(input logic [2:0] op, input logic [15:0] imm,
                       input logic [63:0] data, input logic [2:0] off);
    b_in_valid = 1'b1;
    b_op = op; b_imm = imm; b_data = data; b_off = off;
  endtask

  // One entry through the 32-bit unit with out_ready high.
  task automatic run_a(input string tag, input logic [2:0] op, input logic [15:0] imm,
                       input logic [31:0] data, input logic [1:0] off,
                       input logic [31:0] exp, input logic exp_err);
    set_a(op, imm, data, off);
    cyc();
    a_in_valid = 1'b0;
    check({tag, "_v"}, a_out_valid, 1'b1);
    check({tag, "_d"}, a_out_data, exp);
    check({tag, "_e"}, a_out_err, exp_err);
  endtask

  task automatic run_b(input string tag, input logic [2:0] op, input logic [15:0] imm,
                       input logic [63:0] data, input logic [2:0] off,
                       input logic [63:0] exp);
    set_b(op, imm, data, off);
    cyc();
    b_in_valid = 1'b0;
    check({tag, "_v"}, b_out_valid, 1'b1);
    check({tag, "_d"}, b_out_data, exp);
    check({tag, "_e"}, b_out_err, 1'b0);
  endtask

  localparam logic [31:0] W = 32'h80FF7F01;

  initial begin
    reset = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_op = '0; a_imm = '0; a_data = '0; a_off = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_op = '0; b_imm = '0; b_data = '0; b_off = '0;
    cyc(); cyc();
    reset = 1'b0;

    check("rst_ovalid", a_out_valid, 1'b0);
    check("rst_irdy", a_in_ready, 1'b1);
    check("rst_odata", a_out_data, 32'h0);
    check("rst_oerr", a_out_err, 1'b0);
    check("rst64_odata", b_out_data, 64'h0);

    a_out_ready = 1'b1;
    run_a("sign8000", 3'd1, 16'h8000, 32'h0, 2'd0, 32'hFFFF8000, 1'b0);
    run_a("sign7fff", 3'd1, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF, 1'b0);
    run_a("lui",      3'd2, 16'h1234, 32'h0, 2'd0, 32'h12340000, 1'b0);
    run_a("lb3",      3'd3, 16'h0, W, 2'd3, 32'hFFFFFF80, 1'b0);
    run_a("lb0",      3'd3, 16'h0, W, 2'd0, 32'h00000001, 1'b0);
    run_a("lbu2",     3'd4, 16'h0, W, 2'd2, 32'h000000FF, 1'b0);
    run_a("lbu3",     3'd4, 16'h0, W, 2'd3, 32'h00000080, 1'b0);
    run_a("lh2",      3'd5, 16'h0, W, 2'd2, 32'hFFFF80FF, 1'b0);
    run_a("lhu0",     3'd6, 16'h0, W, 2'd0, 32'h00007F01, 1'b0);
    run_a("pass",     3'd7, 16'h0, W, 2'd0, W, 1'b0);
    run_a("zero",     3'd0, 16'hFFFF, 32'h0, 2'd0, 32'h0000FFFF, 1'b0);
    run_a("lh1_mis",  3'd5, 16'h0, W, 2'd1, 32'h0, 1'b1);
    run_a("lhu2",     3'd6, 16'h0, W, 2'd2, 32'h000080FF, 1'b0);
    run_a("lhu3_mis", 3'd6, 16'h0, W, 2'd3, 32'h0, 1'b1);
    cyc();
    check("drain_ovalid", a_out_valid, 1'b0);

    // Backpressure: A and B absorbed, C held off until the first pop.
    a_out_ready = 1'b0;
    set_a(3'd0, 16'h0011, 32'h0, 2'd0); exp_q.push_back(64'h11); cyc();
    check("bp_irdy_a", a_in_ready, 1'b1);
    check("bp_head_a", a_out_data, exp_q[0]);
    set_a(3'd0, 16'h0022, 32'h0, 2'd0); exp_q.push_back(64'h22); cyc();
    check("bp_irdy_b", a_in_ready, 1'b0);
    check("bp_ovalid_b", a_out_valid, 1'b1);
    set_a(3'd1, 16'h8033, 32'h0, 2'd0); cyc();
    check("bp_irdy_c", a_in_ready, 1'b0);
    check("bp_hold", a_out_data, exp_q[0]);
    a_out_ready = 1'b1; void'(exp_q.pop_front()); cyc();
    check("bp_pop_b", a_out_data, exp_q.pop_front());
    check("bp_irdy_ret", a_in_ready, 1'b1);
    exp_q.push_back(64'hFFFF8033); cyc();
    a_in_valid = 1'b0;
    check("bp_c_valid", a_out_valid, 1'b1);
    check("bp_c_data", a_out_data, exp_q.pop_front());
    cyc();
    check("bp_empty", a_out_valid, 1'b0);

    // Flush with a full buffer and a same-cycle input.
    a_out_ready = 1'b0;
    set_a(3'd0, 16'h0044, 32'h0, 2'd0); cyc();
    set_a(3'd0, 16'h0055, 32'h0, 2'd0); cyc();
    check("fl_full", a_in_ready, 1'b0);
    set_a(3'd0, 16'h0066, 32'h0, 2'd0); flush = 1'b1; cyc();
    flush = 1'b0; a_in_valid = 1'b0;
    check("fl_ovalid", a_out_valid, 1'b0);
    check("fl_irdy", a_in_ready, 1'b1);
    a_out_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("fl_no_ghost", a_out_valid, 1'b0);
    run_a("fl_after", 3'd0, 16'h0077, 32'h0, 2'd0, 32'h00000077, 1'b0);
    cyc();

    // Reset mid-stream drops the held entry.
    a_out_ready = 1'b0;
    set_a(3'd0, 16'h0088, 32'h0, 2'd0); cyc();
    a_in_valid = 1'b0;
    check("mr_pre", a_out_valid, 1'b1);
    reset = 1'b1; cyc();
    reset = 1'b0;
    check("mr_ovalid", a_out_valid, 1'b0);
    check("mr_irdy", a_in_ready, 1'b1);
    check("mr_odata", a_out_data, 32'h0);

    // 64-bit instance.
    b_out_ready = 1'b1;
    run_b("b_lui",  3'd2, 16'hABCD, 64'h0, 3'd0, 64'hABCD000000000000);
    run_b("b_lb7",  3'd3, 16'h0, 64'h80000000_00000000, 3'd7, 64'hFFFFFFFFFFFFFF80);
    run_b("b_lh6",  3'd5, 16'h0, 64'h80010000_00000000, 3'd6, 64'hFFFFFFFFFFFF8001);
    run_b("b_sign", 3'd1, 16'h8000, 64'h0, 3'd0, 64'hFFFFFFFFFFFF8000);
    cyc();
    check("b_idle", b_out_valid, 1'b0);

    // Streaming: one entry accepted and one popped every cycle.
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check($sformatf("st_v%0d", i), b_out_valid, 1'b1);
        if (exp_q.size() > 0) check($sformatf("st_d%0d", i), b_out_data, exp_q.pop_front());
      end
      if (i < 8) begin
        set_b(3'd0, 16'(i * 16'h1111 + 1), 64'h0, 3'd0);
        exp_q.push_back(64'(i * 16'h1111 + 1));
        check($sformatf("st_r%0d", i), b_in_ready, 1'b1);
      end else begin
        b_in_valid = 1'b0;
      end
      cyc();
    end
    check("st_end", b_out_valid, 1'b0);
    check("st_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
